// File: rtl/phys_sim_pkg.sv
// Shared types and constants for the scenario path.
//   loader_state_t : scenario_loader FSM states
//   SCEN_W         : default width of the switch bus / scenario select
package phys_sim_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DEBOUNCE,
        ST_LOAD
    } loader_state_t;

    localparam int SCEN_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk_i domain.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset; both stages clear to 0
//   d_i   : asynchronous input bus (W bits)
//   q_o   : synchronized output (W bits), two cycles of latency
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/scenario_loader.sv
// Scenario front end: synchronizes and debounces the board switches and the
// reload button, commits a stable switch value as the scenario select, and
// holds the physics engine in reset for a fixed window on every load so it
// restarts from the selected initial conditions.
// Ports:
//   clock_162  : system clock
//   rst        : synchronous active-high reset
//   sw_in      : raw switches (asynchronous)
//   reload_in  : raw reload button (asynchronous)
//   sel        : committed scenario select (registered)
//   engine_run : 1 = engine runs; 0 holds the engine in reset (registered)
//   load_pulse : one-cycle strobe on the first RUN cycle after every load
//   busy       : 1 whenever the FSM is not in RUN
module scenario_loader
    import phys_sim_pkg::*;
#(
    parameter int SW_WIDTH        = SCEN_W,
    parameter int DEBOUNCE_CYCLES = 1_620_000,
    parameter int LOAD_CYCLES     = 16
) (
    input  logic                clock_162,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_in,
    input  logic                reload_in,
    output logic [SW_WIDTH-1:0] sel,
    output logic                engine_run,
    output logic                load_pulse,
    output logic                busy
);

    // One counter serves both the debounce and the load windows.
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + LOAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LAST = CNT_W'(LOAD_CYCLES - 1);

    logic [SW_WIDTH-1:0] sw_s;
    logic                rl_s;

    sync_2ff #(.W(SW_WIDTH)) u_sw_sync (
        .clk_i (clock_162),
        .rst_i (rst),
        .d_i   (sw_in),
        .q_o   (sw_s)
    );

    sync_2ff #(.W(1)) u_rl_sync (
        .clk_i (clock_162),
        .rst_i (rst),
        .d_i   (reload_in),
        .q_o   (rl_s)
    );

    loader_state_t       state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [SW_WIDTH-1:0] cand_q;
    logic [SW_WIDTH-1:0] sel_q;
    logic                run_q;
    logic                pulse_q;
    logic                busy_q;
    logic                rl_q;
    logic                rl_rise;

    // A held button produces a single rising edge, hence a single load.
    assign rl_rise = rl_s & ~rl_q;
    assign cnt_d   = cnt_q + CNT_W'(1);

    always_ff @(posedge clock_162) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            cand_q  <= '0;
            sel_q   <= '0;
            run_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b1;
            rl_q    <= 1'b0;
        end else begin
            rl_q    <= rl_s;
            pulse_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // A switch change wins over a simultaneous reload.
                    if (sw_s != sel_q) begin
                        cand_q  <= sw_s;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_DEBOUNCE;
                    end else if (rl_rise) begin
                        cnt_q   <= '0;
                        run_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_DEBOUNCE: begin
                    // The engine keeps running the old scenario meanwhile;
                    // reload is ignored here since a commit reloads anyway.
                    if (sw_s == sel_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end else if (sw_s != cand_q) begin
                        cand_q <= sw_s;
                        cnt_q  <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        // sel and engine_run change on the same edge so the
                        // engine never sees a new select while running.
                        sel_q   <= cand_q;
                        run_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_LOAD: begin
                    // Switch changes are picked up by the RUN mismatch check.
                    if (cnt_q == LD_LAST) begin
                        cnt_q   <= '0;
                        run_q   <= 1'b1;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    run_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign engine_run = run_q;
    assign load_pulse = pulse_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scenario_loader.sv
module tb_scenario_loader;

    localparam int SW = 16;

    logic          clock_162 = 1'b0;
    logic          rst       = 1'b1;
    logic [SW-1:0] sw_in     = '0;
    logic          reload_in = 1'b0;
    logic [SW-1:0] sel;
    logic          engine_run;
    logic          load_pulse;
    logic          busy;

    always #5 clock_162 = ~clock_162;

    scenario_loader #(
        .SW_WIDTH        (SW),
        .DEBOUNCE_CYCLES (8),
        .LOAD_CYCLES     (4)
    ) dut (
        .clock_162  (clock_162),
        .rst        (rst),
        .sw_in      (sw_in),
        .reload_in  (reload_in),
        .sel        (sel),
        .engine_run (engine_run),
        .load_pulse (load_pulse),
        .busy       (busy)
    );

    typedef struct {
        logic          rst;
        logic [SW-1:0] sw;
        logic          rl;
        int            n;      // edges this row is applied for
        logic [SW-1:0] sel;
        logic          run;
        logic          pulse;
        logic          busy;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-window activity counters, only touched by the main initial block.
    int   pulses, low_cyc, falls, busy_cyc, saw6;
    logic prev_run;

    task automatic tick();
        @(posedge clock_162);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    task automatic chk_out(input string name, input logic [SW-1:0] e_sel, input logic e_run,
                           input logic e_pulse, input logic e_busy);
        chk(name, {13'd0, sel, engine_run, load_pulse, busy},
                  {13'd0, e_sel, e_run, e_pulse, e_busy});
    endtask

    task automatic clear_mon();
        pulses   = 0;
        low_cyc  = 0;
        falls    = 0;
        busy_cyc = 0;
        saw6     = 0;
        prev_run = engine_run;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (load_pulse) pulses++;
            if (!engine_run) low_cyc++;
            if (prev_run && !engine_run) falls++;
            if (busy) busy_cyc++;
            if (sel == 16'd6) saw6++;
            prev_run = engine_run;
        end
    endtask

    vec_t tbl[9];

    initial begin
        // Post-reset load, then a clean 0->5 change (commit on edge 11).
        tbl[0] = '{1'b1, 16'd0, 1'b0, 3, 16'd0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 16'd0, 1'b0, 3, 16'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 16'd0, 1'b0, 1, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 16'd0, 1'b0, 2, 16'd0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'd5, 1'b0, 2, 16'd0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'd5, 1'b0, 8, 16'd0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'd5, 1'b0, 4, 16'd5, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 16'd5, 1'b0, 1, 16'd5, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 16'd5, 1'b0, 2, 16'd5, 1'b1, 1'b0, 1'b0};

        for (int r = 0; r < 9; r++) begin
            rst       = tbl[r].rst;
            sw_in     = tbl[r].sw;
            reload_in = tbl[r].rl;
            for (int k = 0; k < tbl[r].n; k++) begin
                tick();
                chk_out($sformatf("vec%0d.%0d", r, k), tbl[r].sel, tbl[r].run,
                        tbl[r].pulse, tbl[r].busy);
            end
        end

        // Reload held 20 cycles: exactly one 4-cycle load, sel unchanged.
        clear_mon();
        reload_in = 1'b1;
        run_cycles(20);
        reload_in = 1'b0;
        run_cycles(10);
        chk("reload_hold.falls", falls, 1);
        chk("reload_hold.low", low_cyc, 4);
        chk("reload_hold.pulses", pulses, 1);
        chk("reload_hold.sel", sel, 5);

        // Reload, then a second press while still loading: no extra load.
        clear_mon();
        reload_in = 1'b1;
        run_cycles(1);
        reload_in = 1'b0;
        for (int i = 0; i < 10 && engine_run; i++) run_cycles(1);
        chk("reload_lp.entered_load", engine_run, 0);
        reload_in = 1'b1;
        run_cycles(1);
        reload_in = 1'b0;
        run_cycles(15);
        chk("reload_lp.falls", falls, 1);
        chk("reload_lp.low", low_cyc, 4);
        chk("reload_lp.pulses", pulses, 1);

        // Back to sel=0.
        rst   = 1'b1;
        sw_in = '0;
        run_cycles(3);
        rst = 1'b0;
        run_cycles(6);
        chk_out("rerst.idle", 16'd0, 1'b1, 1'b0, 1'b0);

        // Glitch: 5 for 5 cycles, back to 0.
        clear_mon();
        sw_in = 16'd5;
        run_cycles(5);
        sw_in = 16'd0;
        run_cycles(15);
        chk("glitch.falls", falls, 0);
        chk("glitch.pulses", pulses, 0);
        chk("glitch.busy_cyc", busy_cyc, 5);
        chk_out("glitch.end", 16'd0, 1'b1, 1'b0, 1'b0);

        // Bounce 5,6,5 then 5 held: single commit of 5.
        clear_mon();
        sw_in = 16'd5; run_cycles(3);
        sw_in = 16'd6; run_cycles(3);
        sw_in = 16'd5; run_cycles(30);
        chk("bounce.falls", falls, 1);
        chk("bounce.low", low_cyc, 4);
        chk("bounce.pulses", pulses, 1);
        chk("bounce.saw6", saw6, 0);
        chk_out("bounce.end", 16'd5, 1'b1, 1'b0, 1'b0);

        // Reset mid-DEBOUNCE at cnt=4.
        sw_in = 16'd9;
        run_cycles(7);
        chk("rst_mid.in_debounce", {engine_run, busy}, 2'b11);
        rst = 1'b1;
        tick();
        chk_out("rst_mid.reset", 16'd0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            logic [SW-1:0] es;
            logic          er, ep, eb;
            tick();
            es = (e >= 13) ? 16'd9 : 16'd0;
            er = !((e < 4) || (e >= 13 && e < 17));
            ep = (e == 4) || (e == 17);
            eb = !((e == 4) || (e >= 17));
            chk_out($sformatf("rst_mid.e%0d", e), es, er, ep, eb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
